// File: rtl/crossbar_pkg.sv
// Shared crossbar types: slave FSM state encoding and transfer command codes.
package crossbar_pkg;

  typedef enum logic [3:0] {
    INIT = 4'b0001,
    IDLE = 4'b0010,
    WAIT = 4'b0100,
    ACK  = 4'b1000
  } slave_state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/slave_regfile.sv
// Word register file for the crossbar slave: synchronous clear, one write port,
// combinational read port.
module slave_regfile #(
  parameter int pDataWidth = 32,
  parameter int pDepth     = 16
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      we,
  input  logic [$clog2(pDepth)-1:0] widx,
  input  logic [pDataWidth-1:0]     wdata,
  input  logic [$clog2(pDepth)-1:0] ridx,
  output logic [pDataWidth-1:0]     rdata
);

  logic [pDataWidth-1:0] mem [pDepth];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < pDepth; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/crossbar_mem_slave.sv
// Crossbar slave endpoint: windowed word register file behind an init delay,
// optional wait states and an error response for out-of-window addresses.
//
// state | meaning
// INIT  | post-reset delay, requests ignored
// IDLE  | ready, captures the next request
// WAIT  | counting wait states on the captured request
// ACK   | one-cycle completion, write commits at end of cycle
module crossbar_mem_slave
  import crossbar_pkg::*;
#(
  parameter int                    pDataWidth  = 32,
  parameter int                    pAddrWidth  = 32,
  parameter int                    pDepth      = 16,
  parameter logic [pAddrWidth-1:0] pBaseAddr   = '0,
  parameter int                    pInit_Delay = 50,
  parameter int                    pWaitStates = 0,
  parameter logic [31:0]           pErrData    = 32'hDEAD_BEEF
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  slave_req,
  input  logic                  slave_cmd,
  input  logic [pAddrWidth-1:0] slave_addr,
  input  logic [pDataWidth-1:0] slave_wdata,
  output logic                  slave_ack,
  output logic                  slave_err,
  output logic [pDataWidth-1:0] slave_rdata,
  output logic                  slave_ready
);

  localparam int BPW       = pDataWidth / 8;
  localparam int BOFS      = $clog2(BPW);
  localparam int IW        = $clog2(pDepth);
  localparam int WIN_BYTES = pDepth * BPW;
  localparam int ICW       = $clog2(pInit_Delay + 1);
  localparam int WCW       = (pWaitStates > 0) ? $clog2(pWaitStates + 1) : 1;

  localparam logic [ICW-1:0]        INIT_LAST = ICW'(pInit_Delay - 1);
  localparam logic [WCW-1:0]        WAIT_LAST = WCW'((pWaitStates > 0) ? pWaitStates - 1 : 0);
  localparam logic [pDataWidth-1:0] ERR_DATA  = pDataWidth'(pErrData);
  localparam logic [pAddrWidth:0]   WIN_END   = (pAddrWidth + 1)'(WIN_BYTES);

  slave_state_t          state;
  logic [ICW-1:0]        init_cnt;
  logic [WCW-1:0]        wait_cnt;

  logic                  cmd_q;
  logic                  hit_q;
  logic [IW-1:0]         idx_q;
  logic [pDataWidth-1:0] wdata_q;

  logic [pAddrWidth-1:0] in_off;
  logic                  in_hit;
  logic [IW-1:0]         in_idx;

  logic                  cur_cmd;
  logic                  cur_hit;
  logic [IW-1:0]         cur_idx;
  logic                  enter_ack;

  logic                  rf_we;
  logic [pDataWidth-1:0] rf_rdata;

  // Unsigned wrap: addresses below the base land far above the window and miss.
  always_comb begin
    in_off = slave_addr - pBaseAddr;
    in_hit = ({1'b0, in_off} < WIN_END);
    in_idx = in_off[BOFS +: IW];
  end

  // With zero wait states the ack is produced on the capture edge itself, so the
  // completion path must see the live request rather than the captured copy.
  always_comb begin
    cur_cmd = cmd_q;
    cur_hit = hit_q;
    cur_idx = idx_q;
    if (state == IDLE) begin
      cur_cmd = slave_cmd;
      cur_hit = in_hit;
      cur_idx = in_idx;
    end
    enter_ack = ((state == IDLE) && slave_req && (pWaitStates == 0)) ||
                ((state == WAIT) && (wait_cnt == WAIT_LAST));
    rf_we     = (state == ACK) && (cmd_q == CMD_WRITE) && hit_q;
  end

  slave_regfile #(
    .pDataWidth (pDataWidth),
    .pDepth     (pDepth)
  ) u_regfile (
    .clk   (iClk),
    .clr   (iRst),
    .we    (rf_we),
    .widx  (idx_q),
    .wdata (wdata_q),
    .ridx  (cur_idx),
    .rdata (rf_rdata)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= INIT;
      init_cnt    <= '0;
      wait_cnt    <= '0;
      cmd_q       <= CMD_READ;
      hit_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      slave_ack   <= 1'b0;
      slave_err   <= 1'b0;
      slave_rdata <= '0;
      slave_ready <= 1'b0;
    end else begin
      slave_ack <= 1'b0;
      slave_err <= 1'b0;

      case (state)
        INIT: begin
          if (init_cnt == INIT_LAST) begin
            state       <= IDLE;
            slave_ready <= 1'b1;
          end else begin
            init_cnt <= init_cnt + ICW'(1);
          end
        end
        IDLE: begin
          if (slave_req) begin
            cmd_q       <= slave_cmd;
            hit_q       <= in_hit;
            idx_q       <= in_idx;
            wdata_q     <= slave_wdata;
            slave_ready <= 1'b0;
            wait_cnt    <= '0;
            state       <= (pWaitStates == 0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= ACK;
          else                       wait_cnt <= wait_cnt + WCW'(1);
        end
        ACK: begin
          state       <= IDLE;
          slave_ready <= 1'b1;
        end
        default: begin
          state       <= INIT;
          init_cnt    <= '0;
          slave_ready <= 1'b0;
        end
      endcase

      if (enter_ack) begin
        slave_ack <= 1'b1;
        slave_err <= ~cur_hit;
        if (cur_cmd == CMD_READ) slave_rdata <= cur_hit ? rf_rdata : ERR_DATA;
      end
    end
  end

endmodule

// File: tb/tb_crossbar_mem_slave.sv
// Directed scoreboard bench: dut_a has no wait states and base 0, dut_b has
// three wait states and base 0x100.
module tb_crossbar_mem_slave;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;
  localparam int   WS_A = 0;
  localparam int   WS_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, req_a, cmd_a, ack_a, err_a, ready_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic        rst_b, req_b, cmd_b, ack_b, err_b, ready_b;
  logic [31:0] addr_b, wdata_b, rdata_b;

  crossbar_mem_slave #(
    .pDataWidth(32), .pAddrWidth(32), .pDepth(16), .pBaseAddr(32'h0000_0000),
    .pInit_Delay(50), .pWaitStates(WS_A), .pErrData(32'hDEAD_BEEF)
  ) dut_a (
    .iClk(clk), .iRst(rst_a), .slave_req(req_a), .slave_cmd(cmd_a),
    .slave_addr(addr_a), .slave_wdata(wdata_a), .slave_ack(ack_a),
    .slave_err(err_a), .slave_rdata(rdata_a), .slave_ready(ready_a)
  );

  crossbar_mem_slave #(
    .pDataWidth(32), .pAddrWidth(32), .pDepth(16), .pBaseAddr(32'h0000_0100),
    .pInit_Delay(50), .pWaitStates(WS_B), .pErrData(32'hDEAD_BEEF)
  ) dut_b (
    .iClk(clk), .iRst(rst_b), .slave_req(req_b), .slave_cmd(cmd_b),
    .slave_addr(addr_b), .slave_wdata(wdata_b), .slave_ack(ack_b),
    .slave_err(err_b), .slave_rdata(rdata_b), .slave_ready(ready_b)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  logic [31:0] model_rd [2];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int sel);
    return (sel == 0) ? ack_a : ack_b;
  endfunction

  function automatic logic err_of(input int sel);
    return (sel == 0) ? err_a : err_b;
  endfunction

  function automatic logic ready_of(input int sel);
    return (sel == 0) ? ready_a : ready_b;
  endfunction

  function automatic logic [31:0] rdata_of(input int sel);
    return (sel == 0) ? rdata_a : rdata_b;
  endfunction

  task automatic drive(input int sel, input logic req, input logic cmd,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel == 0) begin
      req_a = req; cmd_a = cmd; addr_a = addr; wdata_a = wdata;
    end else begin
      req_b = req; cmd_b = cmd; addr_b = addr; wdata_b = wdata;
    end
  endtask

  task automatic push_exp(input int sel, input logic cmd, input logic err, input logic [31:0] rd);
    exp_t e;
    e.err   = err;
    e.rdata = (cmd == RD) ? rd : model_rd[sel];
    model_rd[sel] = e.rdata;
    if (sel == 0) sb_a.push_back(e);
    else          sb_b.push_back(e);
  endtask

  task automatic chk_pop(input int sel, input string tag);
    exp_t e;
    int   sz;
    sz = (sel == 0) ? sb_a.size() : sb_b.size();
    total++;
    assert (sz > 0) else begin
      bad++;
      $error("FAIL %s_sb unexpected ack observed=1 expected=0", tag);
    end
    if (sz > 0) begin
      if (sel == 0) e = sb_a.pop_front();
      else          e = sb_b.pop_front();
      chk({tag, "_err"},   32'(err_of(sel)), 32'(e.err));
      chk({tag, "_rdata"}, rdata_of(sel),    e.rdata);
    end
  endtask

  task automatic wait_ready(input int sel, input string tag);
    int n     = 0;
    int stray = 0;
    do begin
      @(negedge clk);
      n++;
      if (ack_of(sel)) stray++;
    end while (!ready_of(sel) && n < 100);
    chk({tag, "_rdy"},   32'(ready_of(sel)), 32'd1);
    chk({tag, "_noack"}, 32'(stray),         32'd0);
  endtask

  task automatic xfer(input int sel, input string tag, input logic cmd,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rd, input bit toggle);
    int cyc     = 0;
    bit seen    = 0;
    int lat_exp = 1 + ((sel == 0) ? WS_A : WS_B);
    wait_ready(sel, tag);
    push_exp(sel, cmd, exp_err, exp_rd);
    drive(sel, 1'b1, cmd, addr, wdata);
    @(posedge clk);
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (ack_of(sel)) begin
        seen = 1;
        cyc  = i;
        drive(sel, 1'b0, RD, 32'h0, 32'h0);
        chk_pop(sel, tag);
      end else if (toggle) begin
        drive(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      end else begin
        drive(sel, 1'b0, RD, 32'h0, 32'h0);
      end
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(lat_exp));
    @(negedge clk);
    chk({tag, "_pulse"}, {30'd0, ack_of(sel), err_of(sel)}, 32'd0);
  endtask

  initial begin
    int ack_a_first, ack_b_first, rdy_a_first, rdy_b_first;
    int nacks, stray;
    int pos [3];

    rst_a = 1'b1; rst_b = 1'b1;
    drive(0, 1'b0, RD, 32'h0, 32'h0);
    drive(1, 1'b0, RD, 32'h0, 32'h0);
    model_rd[0] = 32'h0;
    model_rd[1] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_a_out", {28'd0, ack_a, err_a, ready_a, 1'b0}, 32'd0);
    chk("rst_a_rdata", rdata_a, 32'h0);
    chk("rst_b_out", {28'd0, ack_b, err_b, ready_b, 1'b0}, 32'd0);
    chk("rst_b_rdata", rdata_b, 32'h0);

    // Init delay with request held from the first cycle out of reset.
    rst_a = 1'b0; rst_b = 1'b0;
    push_exp(0, RD, 1'b0, 32'h0);
    push_exp(1, RD, 1'b0, 32'h0);
    drive(0, 1'b1, RD, 32'h0000_0008, 32'h0);
    drive(1, 1'b1, RD, 32'h0000_0104, 32'h0);
    ack_a_first = -1; ack_b_first = -1; rdy_a_first = -1; rdy_b_first = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (ready_a && rdy_a_first < 0) rdy_a_first = i;
      if (ready_b && rdy_b_first < 0) rdy_b_first = i;
      if (ack_a && ack_a_first < 0) begin
        ack_a_first = i;
        chk_pop(0, "t1_a");
        drive(0, 1'b0, RD, 32'h0, 32'h0);
      end
      if (ack_b && ack_b_first < 0) begin
        ack_b_first = i;
        chk_pop(1, "t1_b");
        drive(1, 1'b0, RD, 32'h0, 32'h0);
      end
    end
    chk("t1_ready_a_cycle", 32'(rdy_a_first), 32'd50);
    chk("t1_ready_b_cycle", 32'(rdy_b_first), 32'd50);
    chk("t1_ack_a_cycle",   32'(ack_a_first), 32'd51);
    chk("t1_ack_b_cycle",   32'(ack_b_first), 32'd54);

    // Zero wait states, base 0.
    xfer(0, "t2_wr",      WR, 32'h0000_0008, 32'h1234_5678, 1'b0, 32'h0,          1'b0);
    xfer(0, "t2_rd",      RD, 32'h0000_0008, 32'h0,         1'b0, 32'h1234_5678, 1'b0);
    xfer(0, "t2_wr_c",    WR, 32'h0000_000C, 32'hCAFE_F00D, 1'b0, 32'h0,          1'b0);
    xfer(0, "t2_rd_unal", RD, 32'h0000_000F, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b0);
    xfer(0, "t2_rd_8",    RD, 32'h0000_0008, 32'h0,         1'b0, 32'h1234_5678, 1'b0);
    xfer(0, "t2_rd_miss", RD, 32'h0000_0040, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0);
    xfer(0, "t2_wr_miss", WR, 32'h0000_0040, 32'h5555_5555, 1'b1, 32'h0,          1'b0);
    xfer(0, "t2_rd_last", RD, 32'h0000_003C, 32'h0,         1'b0, 32'h0,          1'b0);

    // Three wait states with inputs toggling during WAIT.
    xfer(1, "t3_rd",  RD, 32'h0000_0108, 32'h0,         1'b0, 32'h0,          1'b1);
    xfer(1, "t3_wr",  WR, 32'h0000_0104, 32'h0BAD_F00D, 1'b0, 32'h0,          1'b1);
    xfer(1, "t3_rdb", RD, 32'h0000_0104, 32'h0,         1'b0, 32'h0BAD_F00D, 1'b1);

    // Window decode around base 0x100.
    xfer(1, "t4_wr_hi",   WR, 32'h0000_0140, 32'h1111_1111, 1'b1, 32'h0,          1'b0);
    xfer(1, "t4_wr_lo",   WR, 32'h0000_00FC, 32'h2222_2222, 1'b1, 32'h0,          1'b0);
    xfer(1, "t4_rd_hi",   RD, 32'h0000_0140, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0);
    xfer(1, "t4_rd_base", RD, 32'h0000_0100, 32'h0,         1'b0, 32'h0,          1'b0);
    xfer(1, "t4_rd_top",  RD, 32'h0000_013C, 32'h0,         1'b0, 32'h0,          1'b0);

    // Request held high across three back-to-back transfers.
    wait_ready(1, "t5");
    for (int k = 0; k < 3; k++) push_exp(1, RD, 1'b0, 32'h0BAD_F00D);
    drive(1, 1'b1, RD, 32'h0000_0104, 32'h0);
    @(posedge clk);
    nacks = 0;
    pos[0] = 0; pos[1] = 0; pos[2] = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (ack_b) begin
        if (nacks < 3) pos[nacks] = i;
        nacks++;
        chk_pop(1, "t5");
        if (nacks == 3) drive(1, 1'b0, RD, 32'h0, 32'h0);
      end
    end
    chk("t5_count", 32'(nacks),         32'd3);
    chk("t5_first", 32'(pos[0]),        32'(1 + WS_B));
    chk("t5_gap1",  32'(pos[1] - pos[0]), 32'(WS_B + 2));
    chk("t5_gap2",  32'(pos[2] - pos[1]), 32'(WS_B + 2));

    // Reset during the WAIT of a write aborts it.
    wait_ready(1, "t6");
    drive(1, 1'b1, WR, 32'h0000_0100, 32'hA5A5_A5A5);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, RD, 32'h0, 32'h0);
    rst_b = 1'b1;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack_b) stray++;
    end
    chk("t6_rst_noack", 32'(stray), 32'd0);
    chk("t6_rst_rdata", rdata_b,    32'h0);
    chk("t6_rst_ready", 32'(ready_b), 32'd0);
    rst_b = 1'b0;
    model_rd[1] = 32'h0;
    xfer(1, "t6_rd0", RD, 32'h0000_0100, 32'h0, 1'b0, 32'h0, 1'b0);
    xfer(1, "t6_rd1", RD, 32'h0000_0104, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
